mlu_div: RTL
============

Name: mlu_div

Overview:
- Sequential restoring divider, the inverse companion of the multiply unit.
- Takes a DW-bit dividend (a product-width value) and a VW-bit divisor (operand width) and returns quotient and remainder.
- Uses the same start/ready handshake as the multiplier, so the same controller can drive both blocks.
- Computes one quotient bit per clock.

Parameters:
- DW, 6, dividend and quotient width (product width of the multiplier)
- VW, 3, divisor and remainder width (operand width of the multiplier)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- dividend  input  DW  numerator, captured on the accepted start edge
- divisor  input  VW  denominator, captured on the accepted start edge
- ready  output  1  high when quotient/remainder are valid; held until the next accepted start
- quotient  output  DW  registered quotient
- remainder  output  VW  registered remainder
- div_zero  output  1  high with ready when the captured divisor was 0

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; ready=0, quotient=0, remainder=0, div_zero=0.
  - All internal registers cleared.
  - Reset mid-operation abandons the computation; no output is produced.
- States:
  - IDLE: waiting after reset.
  - BUSY: iterating.
  - DONE: result held.
- IDLE/DONE with start=1 at an edge (edge 0):
  - Capture dividend into shift register D and divisor into V.
  - Clear partial remainder R (VW+1 bits) and quotient shift register Q.
  - Set step counter to DW; ready=0, div_zero=0.
  - If the divisor is nonzero: go to BUSY.
  - If the divisor is 0: go to a single-cycle ZERO path, then DONE at edge 1 with quotient=all ones (2^DW-1), remainder=0, div_zero=1, ready=1.
- BUSY, each edge, one restoring step:
  - T = {R[VW-1:0], D[DW-1]}; D shifts left by 1.
  - If T >= V: R = T - V and shift 1 into Q LSB; else R = T and shift 0.
  - Decrement the counter.
  - On the edge where the counter reaches 0: load quotient=Q final, remainder=R[VW-1:0], set ready=1, go to DONE.
- Latency: ready and outputs become valid after edge DW, i.e. DW cycles after the capture edge (6 for the defaults). Divide-by-zero takes 1 cycle.
- start is ignored in BUSY; operand inputs may change freely after capture.
- start held high continuously in DONE restarts immediately: ready drops on that edge and the outputs keep their old values until the new completion.
- Outputs change only on the completion edge or on reset; they are stable through BUSY.
- Arithmetic is unsigned. R never exceeds 2·V-1 before subtraction, so VW+1 bits suffice. The final remainder is always < divisor.

Optional Feature:
- Macro: MLU_DIV_CHECK_EN.
- When defined:
  - Adds output port chk_err (1 bit, reset 0).
  - On the completion edge, recompute quotient*divisor + remainder combinationally (DW+VW bits) and compare it against the captured dividend.
  - chk_err is set to 1 on a mismatch, 0 on a match, and is valid with ready.
  - Divide-by-zero completions force chk_err=0.
- When undefined: no chk_err port and no check logic; all other behaviour is identical.

Test Plan:
- Reset, then start with dividend=42, divisor=5 -> ready rises exactly 6 cycles after the capture edge; quotient=8, remainder=2, div_zero=0.
- Back-to-back operations: dividend=63, divisor=1 -> 63 r0, then dividend=63, divisor=7 -> 9 r0, then dividend=0, divisor=3 -> 0 r0. start is held high through DONE; ready drops for each new operation.
- dividend=17, divisor=0 -> 1 cycle later ready=1, div_zero=1, quotient=63, remainder=0. Then a normal divide 20/6 -> 3 r2 with div_zero=0.
- start pulsed in cycle 3 of BUSY with different operands during 45/4 -> ignored; result is 11 r1 on schedule.
- rst_n asserted at cycle 2 of 50/3 -> outputs zero immediately and state returns to IDLE. A fresh 50/3 then gives 16 r2.
- With MLU_DIV_CHECK_EN: sweep all 64×7 nonzero-divisor combinations -> chk_err=0 for every completion, and results match a reference model.

Source files
------------

// File: rtl/mlu_div.sv
// mlu_div: sequential restoring divider, one quotient bit per clock, start/ready handshake.
// Optional self-check output chk_err is enabled by defining MLU_DIV_CHECK_EN.
module mlu_div #(
    parameter int DW = 6,
    parameter int VW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_zero
`ifdef MLU_DIV_CHECK_EN
    , output logic        chk_err
`endif
);
    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {IDLE, BUSY, ZERO, DONE} state_t;

    state_t        state, state_nx;
    logic [DW-1:0] d, q, q_nx;
    logic [VW-1:0] v, r, r_nx;
    logic [VW:0]   t;
    logic [CW-1:0] cnt;
    logic          ge, accept, last;

    // The partial remainder stays below V after each step, so the extra bit lives only in T.
    always_comb begin
        accept = start && (state == IDLE || state == DONE);
        t      = {r, d[DW-1]};
        ge     = t >= {1'b0, v};
        r_nx   = ge ? VW'(t - {1'b0, v}) : t[VW-1:0];
        q_nx   = {q[DW-2:0], ge};
        last   = cnt == CW'(1);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (accept) state_nx = (divisor == '0) ? ZERO : BUSY;
            BUSY:       if (last) state_nx = DONE;
            ZERO:       state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

`ifdef MLU_DIV_CHECK_EN
    localparam int PW = DW + VW;
    logic [DW-1:0] dvd;
    logic [PW-1:0] prod;
    always_comb prod = PW'(q_nx) * PW'(v) + PW'(r_nx);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d         <= '0;
            v         <= '0;
            r         <= '0;
            q         <= '0;
            cnt       <= '0;
            ready     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
`ifdef MLU_DIV_CHECK_EN
            dvd       <= '0;
            chk_err   <= 1'b0;
`endif
        end else if (accept) begin
            d        <= dividend;
            v        <= divisor;
            r        <= '0;
            q        <= '0;
            cnt      <= CW'(DW);
            ready    <= 1'b0;
            div_zero <= 1'b0;
`ifdef MLU_DIV_CHECK_EN
            dvd      <= dividend;
`endif
        end else if (state == BUSY) begin
            d   <= {d[DW-2:0], 1'b0};
            r   <= r_nx;
            q   <= q_nx;
            cnt <= cnt - CW'(1);
            if (last) begin
                quotient  <= q_nx;
                remainder <= r_nx;
                ready     <= 1'b1;
`ifdef MLU_DIV_CHECK_EN
                chk_err   <= prod != PW'(dvd);
`endif
            end
        end else if (state == ZERO) begin
            quotient  <= '1;
            remainder <= '0;
            div_zero  <= 1'b1;
            ready     <= 1'b1;
`ifdef MLU_DIV_CHECK_EN
            chk_err   <= 1'b0;
`endif
        end
    end
endmodule
